// File: rtl/serial_digit_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : serial_digit_adder_if
//  Description : Start/done handshake and operand/result bundle for the
//                digit-serial adder/subtractor.
//  Revision    : 1.0  initial release
// ============================================================================
interface serial_digit_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic             Cin;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             Ovf;

  // Controller side: issues operations and consumes results
  modport master (
    output start, sub, Cin, X, Y,
    input  busy, done, S, Cout, Ovf
  );

  // Adder side
  modport slave (
    input  start, sub, Cin, X, Y,
    output busy, done, S, Cout, Ovf
  );
endinterface
`default_nettype wire

// File: rtl/serial_digit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_digit_adder
//  Description : Multi-cycle WIDTH-bit adder/subtractor, DIGIT bits per clock,
//                carry held in a register between digits.
//  Revision    : 1.0  initial release
// ============================================================================
module serial_digit_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  wire                   clk,
  input  wire                   rst_n,
  serial_digit_adder_if.slave   bus
);

  localparam int c_n  = WIDTH / DIGIT;
  localparam int c_kw = (c_n > 1) ? $clog2(c_n) : 1;

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_run  = 2'd1;
  localparam logic [1:0] c_st_done = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;

  // Operands shift right each RUN cycle so the active digit is always at bit 0
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [c_kw-1:0]  r_k;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [DIGIT:0]   w_c;
  logic [DIGIT-1:0] w_sum;

  assign w_accept = bus.start && (r_state != c_st_run);
  assign w_last   = (r_k == c_kw'(c_n - 1));

  assign w_c[0] = r_carry;

  for (genvar i = 0; i < DIGIT; i++) begin : g_ripple
    assign w_sum[i]   = r_a[i] ^ r_b[i] ^ w_c[i];
    assign w_c[i+1]   = (r_a[i] & r_b[i]) | (w_c[i] & (r_a[i] ^ r_b[i]));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle: if (bus.start) w_state_nxt = c_st_run;
      c_st_run:  if (w_last)    w_state_nxt = c_st_done;
      c_st_done: w_state_nxt = bus.start ? c_st_run : c_st_idle;
      default:   w_state_nxt = c_st_idle;
    endcase
  end

  // Output decode
  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    case (r_state)
      c_st_run:  bus.busy = 1'b1;
      c_st_done: bus.done = 1'b1;
      default: begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, digit add, result write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_k     <= '0;
      r_s     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= bus.X;
      r_b     <= bus.sub ? ~bus.Y : bus.Y;
      r_carry <= bus.sub ? 1'b1 : bus.Cin;
      r_k     <= '0;
    end else if (r_state == c_st_run) begin
      r_a     <= r_a >> DIGIT;
      r_b     <= r_b >> DIGIT;
      r_carry <= w_c[DIGIT];
      for (int d = 0; d < c_n; d++) begin
        if (r_k == c_kw'(d)) begin
          r_s[d*DIGIT +: DIGIT] <= w_sum;
        end
      end
      if (w_last) begin
        r_cout <= w_c[DIGIT];
        // Carry into the MSB is the carry into the top bit of the last digit
        r_ovf  <= w_c[DIGIT-1] ^ w_c[DIGIT];
      end else begin
        r_k    <= r_k + c_kw'(1);
      end
    end
  end

  assign bus.S    = r_s;
  assign bus.Cout = r_cout;
  assign bus.Ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_digit_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_digit_adder
//  Description : Directed and randomised self-checking bench for serial_digit_adder
//  Revision    : 1.0  initial release
// ============================================================================
module tb_serial_digit_adder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  serial_digit_adder_if #(.WIDTH(8))  m_if ();
  serial_digit_adder_if #(.WIDTH(8))  if81 ();
  serial_digit_adder_if #(.WIDTH(8))  if88 ();
  serial_digit_adder_if #(.WIDTH(16)) if164 ();
  serial_digit_adder_if #(.WIDTH(4))  if44 ();

  serial_digit_adder #(.WIDTH(8),  .DIGIT(2)) u_dut   (.clk(clk), .rst_n(rst_n), .bus(m_if));
  serial_digit_adder #(.WIDTH(8),  .DIGIT(1)) u_d81   (.clk(clk), .rst_n(rst_n), .bus(if81));
  serial_digit_adder #(.WIDTH(8),  .DIGIT(8)) u_d88   (.clk(clk), .rst_n(rst_n), .bus(if88));
  serial_digit_adder #(.WIDTH(16), .DIGIT(4)) u_d164  (.clk(clk), .rst_n(rst_n), .bus(if164));
  serial_digit_adder #(.WIDTH(4),  .DIGIT(4)) u_d44   (.clk(clk), .rst_n(rst_n), .bus(if44));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: {Ovf, Cout, S[15:0]} for a w-bit operation
  function automatic logic [17:0] model(input int w, input logic [15:0] x, input logic [15:0] y,
                                        input logic sb, input logic ci);
    logic [16:0] mask;
    logic [16:0] a;
    logic [16:0] b;
    logic [16:0] r;
    logic [15:0] s;
    logic        co;
    logic        ov;
    mask = (17'd1 << w) - 17'd1;
    a    = {1'b0, x} & mask;
    b    = (sb ? {1'b0, ~y} : {1'b0, y}) & mask;
    r    = a + b + {16'd0, (sb ? 1'b1 : ci)};
    co   = r[w];
    s    = r[15:0] & mask[15:0];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  task automatic start_main(input logic [7:0] x, input logic [7:0] y, input logic sb, input logic ci);
    m_if.X = x; m_if.Y = y; m_if.sub = sb; m_if.Cin = ci; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    // Scramble inputs after accept; the result must not depend on them
    m_if.X = ~x; m_if.Y = ~y; m_if.sub = ~sb; m_if.Cin = ~ci;
  endtask

  // lat = number of edges (accept edge counted as 1) until done is seen; 0 on timeout
  task automatic wait_main(input int base, output int lat);
    lat = 0;
    for (int e = base; e <= base + 12; e++) begin
      if (m_if.done) begin
        lat = e;
        break;
      end
      tick();
    end
  endtask

  task automatic sweep_op(input logic [15:0] x, input logic [15:0] y, input logic sb, input logic ci);
    int lat [4];
    lat = '{default: 0};
    if81.X  = x[7:0];  if81.Y  = y[7:0];  if81.sub  = sb; if81.Cin  = ci; if81.start  = 1'b1;
    if88.X  = x[7:0];  if88.Y  = y[7:0];  if88.sub  = sb; if88.Cin  = ci; if88.start  = 1'b1;
    if164.X = x;       if164.Y = y;       if164.sub = sb; if164.Cin = ci; if164.start = 1'b1;
    if44.X  = x[3:0];  if44.Y  = y[3:0];  if44.sub  = sb; if44.Cin  = ci; if44.start  = 1'b1;
    tick();
    if81.start = 1'b0; if88.start = 1'b0; if164.start = 1'b0; if44.start = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      if (if81.done  && lat[0] == 0) lat[0] = e;
      if (if88.done  && lat[1] == 0) lat[1] = e;
      if (if164.done && lat[2] == 0) lat[2] = e;
      if (if44.done  && lat[3] == 0) lat[3] = e;
      tick();
    end
    chk("lat_w8d1",  lat[0], 9);
    chk("lat_w8d8",  lat[1], 2);
    chk("lat_w16d4", lat[2], 5);
    chk("lat_w4d4",  lat[3], 2);
    chk("res_w8d1",  {14'd0, if81.Ovf,  if81.Cout,  8'h00, if81.S},  {14'd0, model(8,  x, y, sb, ci)});
    chk("res_w8d8",  {14'd0, if88.Ovf,  if88.Cout,  8'h00, if88.S},  {14'd0, model(8,  x, y, sb, ci)});
    chk("res_w16d4", {14'd0, if164.Ovf, if164.Cout, if164.S},        {14'd0, model(16, x, y, sb, ci)});
    chk("res_w4d4",  {14'd0, if44.Ovf,  if44.Cout,  12'h000, if44.S}, {14'd0, model(4,  x, y, sb, ci)});
  endtask

  initial begin
    int lat;
    int ndone;
    logic [15:0] cx [6];
    logic [15:0] cy [6];
    logic [1:0]  cm [6];

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    m_if.start = 1'b0; m_if.sub = 1'b0; m_if.Cin = 1'b0; m_if.X = '0; m_if.Y = '0;
    if81.start = 1'b0; if81.sub = 1'b0; if81.Cin = 1'b0; if81.X = '0; if81.Y = '0;
    if88.start = 1'b0; if88.sub = 1'b0; if88.Cin = 1'b0; if88.X = '0; if88.Y = '0;
    if164.start = 1'b0; if164.sub = 1'b0; if164.Cin = 1'b0; if164.X = '0; if164.Y = '0;
    if44.start = 1'b0; if44.sub = 1'b0; if44.Cin = 1'b0; if44.X = '0; if44.Y = '0;
    tick(); tick(); tick();

    chk("rst_busy", {31'd0, m_if.busy}, 0);
    chk("rst_done", {31'd0, m_if.done}, 0);
    chk("rst_S",    {24'd0, m_if.S},    0);
    chk("rst_cout", {31'd0, m_if.Cout}, 0);
    chk("rst_ovf",  {31'd0, m_if.Ovf},  0);
    rst_n = 1'b1;
    tick();

    // 0x5A + 0x3C
    start_main(8'h5A, 8'h3C, 1'b0, 1'b0);
    chk("t1_busy", {31'd0, m_if.busy}, 1);
    wait_main(1, lat);
    chk("t1_lat",  lat, 5);
    chk("t1_S",    {24'd0, m_if.S}, 32'h96);
    chk("t1_cout", {31'd0, m_if.Cout}, 0);
    chk("t1_ovf",  {31'd0, m_if.Ovf},  1);
    tick();
    chk("t1_done_low", {31'd0, m_if.done}, 0);
    chk("t1_idle",     {31'd0, m_if.busy}, 0);
    chk("t1_S_hold",   {24'd0, m_if.S}, 32'h96);

    // 0x10 - 0x20 and 0x80 - 0x01
    start_main(8'h10, 8'h20, 1'b1, 1'b0);
    wait_main(1, lat);
    chk("t2a_lat",  lat, 5);
    chk("t2a_S",    {24'd0, m_if.S}, 32'hF0);
    chk("t2a_cout", {31'd0, m_if.Cout}, 0);
    chk("t2a_ovf",  {31'd0, m_if.Ovf},  0);
    tick();
    start_main(8'h80, 8'h01, 1'b1, 1'b1);
    wait_main(1, lat);
    chk("t2b_lat",  lat, 5);
    chk("t2b_S",    {24'd0, m_if.S}, 32'h7F);
    chk("t2b_cout", {31'd0, m_if.Cout}, 1);
    chk("t2b_ovf",  {31'd0, m_if.Ovf},  1);
    tick();

    // 0xFF + 0x00 + 1 with start re-pulsed during RUN
    start_main(8'hFF, 8'h00, 1'b0, 1'b1);
    tick();
    m_if.start = 1'b1; m_if.X = 8'h12; m_if.Y = 8'h34; m_if.sub = 1'b0; m_if.Cin = 1'b0;
    tick(); tick();
    m_if.start = 1'b0;
    wait_main(4, lat);
    chk("t3_lat",  lat, 5);
    chk("t3_S",    {24'd0, m_if.S}, 32'h00);
    chk("t3_cout", {31'd0, m_if.Cout}, 1);
    chk("t3_ovf",  {31'd0, m_if.Ovf},  0);
    // Back-to-back start issued in the DONE cycle
    m_if.X = 8'h7F; m_if.Y = 8'h01; m_if.sub = 1'b0; m_if.Cin = 1'b0; m_if.start = 1'b1;
    tick();
    m_if.start = 1'b0;
    chk("t3_one_done", {31'd0, m_if.done}, 0);
    chk("t3_b2b_busy", {31'd0, m_if.busy}, 1);
    wait_main(1, lat);
    chk("t3_b2b_lat",  lat, 5);
    chk("t3_b2b_S",    {24'd0, m_if.S}, 32'h80);
    chk("t3_b2b_cout", {31'd0, m_if.Cout}, 0);
    chk("t3_b2b_ovf",  {31'd0, m_if.Ovf},  1);
    tick();

    // Asynchronous reset at the second RUN edge
    start_main(8'h11, 8'h22, 1'b0, 1'b0);
    tick();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t4_busy", {31'd0, m_if.busy}, 0);
    chk("t4_done", {31'd0, m_if.done}, 0);
    chk("t4_S",    {24'd0, m_if.S},    0);
    chk("t4_cout", {31'd0, m_if.Cout}, 0);
    chk("t4_ovf",  {31'd0, m_if.Ovf},  0);
    @(negedge clk);
    tick();
    rst_n = 1'b1;
    ndone = 0;
    for (int e = 0; e < 8; e++) begin
      if (m_if.done) ndone++;
      tick();
    end
    chk("t4_no_done", ndone, 0);
    start_main(8'h33, 8'h44, 1'b0, 1'b1);
    wait_main(1, lat);
    chk("t4_lat",  lat, 5);
    chk("t4_S",    {24'd0, m_if.S}, 32'h78);
    chk("t4_cout", {31'd0, m_if.Cout}, 0);
    chk("t4_ovf",  {31'd0, m_if.Ovf},  0);
    tick();

    // Configuration sweep: corner vectors then random ones; cm = {sub, Cin}
    cx = '{16'hFFFF, 16'h0000, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF};
    cy = '{16'h0001, 16'h0000, 16'h0001, 16'h0001, 16'hFFFF, 16'hFFFF};
    cm = '{2'b00,    2'b10,    2'b10,    2'b00,    2'b01,    2'b01};
    for (int i = 0; i < 6; i++) begin
      sweep_op(cx[i], cy[i], cm[i][1], cm[i][0]);
    end
    for (int i = 0; i < 300; i++) begin
      sweep_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
